// File: rtl/rysy_mem_arbiter.sv
// Two-master round-robin arbiter (rysy_core bus = m0, loader/debug = m1) in front of one single-port sync RAM.
// Latency: grant is combinational in the request cycle; rvalid/rdata follow exactly one cycle after the grant.
// Backpressure: a master holds req and fields until gnt; m0 waits indefinitely while m1 holds the lock.
module rysy_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [DATA_W/8-1:0] m0_be,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [DATA_W/8-1:0] m1_be,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic                m1_lock,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;  // 1 = m1 was granted most recently
  logic              resp_valid_q;
  logic              resp_owner_q;                // 1 = response belongs to m1
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  // Grant decision and next-state; nothing is granted while reset is held.
  always_comb begin
    m0_gnt       = 1'b0;
    m1_gnt       = 1'b0;
    state_d      = state_q;
    last_grant_d = last_grant_q;
    if (rst) begin
      case (state_q)
        ARB: begin
          if (m0_req && m1_req) begin
            m0_gnt = last_grant_q;
            m1_gnt = !last_grant_q;
          end else begin
            m0_gnt = m0_req;
            m1_gnt = m1_req;
          end
        end
        LOCKED: m1_gnt = m1_req;
        default: ;
      endcase
      if (m0_gnt) last_grant_d = 1'b0;
      if (m1_gnt) begin
        last_grant_d = 1'b1;
        // Every granted m1 access re-decides the lock from its own lock bit.
        state_d      = m1_lock ? LOCKED : ARB;
      end
    end
  end

  // RAM port mux; address/data hold their last granted values when idle.
  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_we    = 1'b0;
    mem_be    = '0;
    if (m0_gnt) begin
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_we    = m0_we;
      mem_be    = m0_be;
    end else if (m1_gnt) begin
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_we    = m1_we;
      mem_be    = m1_be;
    end
  end

  // Arbitration state, response tracking and held RAM address/data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB;
      last_grant_q <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_owner_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      resp_valid_q <= m0_gnt | m1_gnt;
      if (m0_gnt | m1_gnt) resp_owner_q <= m1_gnt;
      addr_q       <= mem_addr;
      wdata_q      <= mem_wdata;
    end
  end

  // Response steering: only the owner sees RAM data, the other side reads zero.
  always_comb begin
    m0_rvalid = resp_valid_q && !resp_owner_q;
    m1_rvalid = resp_valid_q &&  resp_owner_q;
    m0_rdata  = m0_rvalid ? mem_rdata : '0;
    m1_rdata  = m1_rvalid ? mem_rdata : '0;
  end

endmodule
